// File: rtl/mux_n_1_stream.sv
// N:1 streaming multiplexer with a registered output stage and per-channel valid/ready.
// Define MUX_N_1_ROUND_ROBIN_EN to build the round-robin arbiter and honour Mode_In.

module mux_n_1_stream_lane #(
  parameter int LANE         = 0,
  parameter int SELECT_WIDTH = 3
) (
  input  logic                    valid,
  input  logic [SELECT_WIDTH-1:0] select,
`ifdef MUX_N_1_ROUND_ROBIN_EN
  input  logic [SELECT_WIDTH-1:0] last_grant,
  output logic                    rr_hit,
`endif
  output logic                    fix_hit
);
  localparam logic [SELECT_WIDTH-1:0] IDX = SELECT_WIDTH'(LANE);

  // Equality against the lane index also rejects out-of-range selects.
  assign fix_hit = valid & (select == IDX);

`ifdef MUX_N_1_ROUND_ROBIN_EN
  assign rr_hit = valid & (IDX > last_grant);
`endif
endmodule

module mux_n_1_stream #(
  parameter int CHANNELS     = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int SELECT_WIDTH = 3
) (
  input  logic                           Clock_In,
  input  logic                           Reset_In,
  input  logic                           Enable_In,
  input  logic                           Mode_In,
  input  logic [SELECT_WIDTH-1:0]        Select_In,
  input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
  input  logic [CHANNELS-1:0]            Valid_In,
  output logic [CHANNELS-1:0]            Ready_Out,
  output logic [DATA_WIDTH-1:0]          Data_Out,
  output logic [SELECT_WIDTH-1:0]        Channel_Out,
  output logic                           Valid_Out,
  input  logic                           Ready_In
);
  logic [CHANNELS-1:0]     fix_grant;
  logic [CHANNELS-1:0]     grant;
  logic                    load;
  logic                    transfer;
  logic [DATA_WIDTH-1:0]   word;
  logic [SELECT_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SELECT_WIDTH-1:0] chan_q;
  logic                    vld_q;

  // Reset gating keeps Ready_Out low for the whole reset cycle.
  assign load = ~Reset_In & Enable_In & (~vld_q | Ready_In);

`ifdef MUX_N_1_ROUND_ROBIN_EN
  logic [SELECT_WIDTH-1:0] last_grant;
  logic [CHANNELS-1:0]     rr_above;
  logic [CHANNELS-1:0]     rr_pool;
  logic [CHANNELS-1:0]     rr_grant;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mux_n_1_stream_lane #(.LANE(c), .SELECT_WIDTH(SELECT_WIDTH)) u_lane (
      .valid      (Valid_In[c]),
      .select     (Select_In),
      .last_grant (last_grant),
      .rr_hit     (rr_above[c]),
      .fix_hit    (fix_grant[c])
    );
  end

  // Channels above the pointer win first; otherwise wrap to the lowest valid,
  // which leaves the last grantee checked last.
  assign rr_pool  = (|rr_above) ? rr_above : Valid_In;
  assign rr_grant = rr_pool & (~rr_pool + CHANNELS'(1));
  assign grant    = Mode_In ? rr_grant : fix_grant;

  always_ff @(posedge Clock_In) begin
    if (Reset_In)      last_grant <= SELECT_WIDTH'(CHANNELS - 1);
    else if (transfer) last_grant <= idx;
  end
`else
  logic unused_mode;
  assign unused_mode = Mode_In;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mux_n_1_stream_lane #(.LANE(c), .SELECT_WIDTH(SELECT_WIDTH)) u_lane (
      .valid   (Valid_In[c]),
      .select  (Select_In),
      .fix_hit (fix_grant[c])
    );
  end

  assign grant = fix_grant;
`endif

  // grant is one-hot or zero, so an AND-OR mux suffices.
  always_comb begin
    word = '0;
    idx  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant[c]) begin
        word = word | Data_In[c*DATA_WIDTH +: DATA_WIDTH];
        idx  = idx | SELECT_WIDTH'(c);
      end
    end
  end

  assign transfer  = load & (|grant);
  assign Ready_Out = {CHANNELS{load}} & grant;

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
    end else if (transfer) begin
      vld_q  <= 1'b1;
      data_q <= word;
      chan_q <= idx;
    end else if (Ready_In) begin
      vld_q  <= 1'b0;
    end
  end

  assign Data_Out    = data_q;
  assign Channel_Out = chan_q;
  assign Valid_Out   = vld_q;
endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed bench for mux_n_1_stream: an 8-channel instance plus a 6-channel one for range checks.

module tb_mux_n_1_stream;
  localparam int CH = 8, DW = 8, SW = 3, CH6 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, mode;
  logic [SW-1:0]    sel, sel6;
  logic [CH*DW-1:0] din;
  logic [CH6*DW-1:0] din6;
  logic [CH-1:0]    vin, rdy;
  logic [CH6-1:0]   vin6, rdy6;
  logic [DW-1:0]    dout, dout6;
  logic [SW-1:0]    cout, cout6;
  logic             vout, vout6, rdy_in, rdy_in6;

  int n_cmp = 0;
  int n_bad = 0;

  mux_n_1_stream #(.CHANNELS(CH), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) u_dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(mode),
    .Select_In(sel), .Data_In(din), .Valid_In(vin), .Ready_Out(rdy),
    .Data_Out(dout), .Channel_Out(cout), .Valid_Out(vout), .Ready_In(rdy_in)
  );

  mux_n_1_stream #(.CHANNELS(CH6), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) u_dut6 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Mode_In(1'b0),
    .Select_In(sel6), .Data_In(din6), .Valid_In(vin6), .Ready_Out(rdy6),
    .Data_Out(dout6), .Channel_Out(cout6), .Valid_Out(vout6), .Ready_In(rdy_in6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = '1; rdy_in = 1'b1; vin6 = '1; rdy_in6 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (rdy !== 8'h00) begin n_bad++; $display("FAIL reset_ready got %h want 00", rdy); end
      n_cmp++; if (vout !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", vout); end
      n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", dout); end
      n_cmp++; if (cout !== 3'd0) begin n_bad++; $display("FAIL reset_chan got %0d want 0", cout); end
      n_cmp++; if (rdy6 !== 6'h00) begin n_bad++; $display("FAIL reset_ready6 got %h want 00", rdy6); end
    end
  endtask

  task automatic test_fixed();
    rst = 1'b0; vin6 = '0; mode = 1'b0; sel = 3'd5; vin = 8'h20; rdy_in = 1'b1;
    #1;
    n_cmp++; if (rdy !== 8'h20) begin n_bad++; $display("FAIL fixed_ready got %h want 20", rdy); end
    n_cmp++; if (vout !== 1'b0) begin n_bad++; $display("FAIL fixed_pre_valid got %b want 0", vout); end
    tick();
    n_cmp++; if (vout !== 1'b1) begin n_bad++; $display("FAIL fixed_valid got %b want 1", vout); end
    n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL fixed_data got %h want a5", dout); end
    n_cmp++; if (cout !== 3'd5) begin n_bad++; $display("FAIL fixed_chan got %0d want 5", cout); end
    vin = 8'h00;
    #1;
    n_cmp++; if (rdy !== 8'h00) begin n_bad++; $display("FAIL fixed_idle_ready got %h want 00", rdy); end
    tick();
    n_cmp++; if (vout !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", vout); end
    n_cmp++; if (dout !== 8'hA5 || cout !== 3'd5) begin
      n_bad++; $display("FAIL drain_hold got %h/%0d want a5/5", dout, cout); end
  endtask

  task automatic test_backpressure();
    sel = 3'd2; vin = 8'h04; rdy_in = 1'b0;
    #1;
    n_cmp++; if (rdy !== 8'h04) begin n_bad++; $display("FAIL bp_empty_ready got %h want 04", rdy); end
    tick();
    sel = 3'd3; vin = 8'h08;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (rdy !== 8'h00) begin n_bad++; $display("FAIL bp_ready got %h want 00", rdy); end
      n_cmp++; if (vout !== 1'b1 || dout !== 8'hA2 || cout !== 3'd2) begin
        n_bad++; $display("FAIL bp_hold got %b/%h/%0d want 1/a2/2", vout, dout, cout); end
      tick();
    end
    rdy_in = 1'b1;
    #1;
    n_cmp++; if (rdy !== 8'h08) begin n_bad++; $display("FAIL bp_release_ready got %h want 08", rdy); end
    tick();
    n_cmp++; if (vout !== 1'b1 || dout !== 8'hA3 || cout !== 3'd3) begin
      n_bad++; $display("FAIL bp_next got %b/%h/%0d want 1/a3/3", vout, dout, cout); end
    vin = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    vin = 8'hFF; rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = SW'(i);
      #1;
      n_cmp++; if (rdy !== 8'(1 << i)) begin n_bad++; $display("FAIL b2b_ready got %h want %h", rdy, 8'(1 << i)); end
      tick();
      n_cmp++; if (vout !== 1'b1 || cout !== SW'(i) || dout !== 8'(8'hA0 + i)) begin
        n_bad++; $display("FAIL b2b_out got %b/%h/%0d want 1/%h/%0d", vout, dout, cout, 8'(8'hA0 + i), i); end
    end
    vin = 8'h00;
    tick();
  endtask

  task automatic test_enable();
    sel = 3'd1; vin = 8'h02; rdy_in = 1'b1; en = 1'b1;
    tick();
    n_cmp++; if (vout !== 1'b1 || dout !== 8'hA1) begin n_bad++; $display("FAIL en_load got %b/%h want 1/a1", vout, dout); end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (rdy !== 8'h00) begin n_bad++; $display("FAIL en_low_ready got %h want 00", rdy); end
      tick();
      n_cmp++; if (vout !== 1'b0 || dout !== 8'hA1) begin
        n_bad++; $display("FAIL en_low_drain got %b/%h want 0/a1", vout, dout); end
    end
    en = 1'b1;
    #1;
    n_cmp++; if (rdy !== 8'h02) begin n_bad++; $display("FAIL en_high_ready got %h want 02", rdy); end
    tick();
    n_cmp++; if (vout !== 1'b1 || cout !== 3'd1) begin n_bad++; $display("FAIL en_reload got %b/%0d want 1/1", vout, cout); end
    vin = 8'h00;
    tick();
  endtask

  task automatic test_out_of_range();
    vin6 = 6'h3F; rdy_in6 = 1'b1;
    for (int s = 6; s < 8; s++) begin
      sel6 = SW'(s);
      #1;
      n_cmp++; if (rdy6 !== 6'h00) begin n_bad++; $display("FAIL oor_ready sel %0d got %h want 00", s, rdy6); end
      tick();
      n_cmp++; if (vout6 !== 1'b0) begin n_bad++; $display("FAIL oor_valid sel %0d got %b want 0", s, vout6); end
    end
    sel6 = 3'd5;
    #1;
    n_cmp++; if (rdy6 !== 6'h20) begin n_bad++; $display("FAIL top_ready got %h want 20", rdy6); end
    tick();
    n_cmp++; if (vout6 !== 1'b1 || dout6 !== 8'hB5 || cout6 !== 3'd5) begin
      n_bad++; $display("FAIL top_out got %b/%h/%0d want 1/b5/5", vout6, dout6, cout6); end
    vin6 = 6'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    sel = 3'd6; vin = 8'h40; rdy_in = 1'b0;
    tick();
    rst = 1'b1; rdy_in = 1'b1;
    #1;
    n_cmp++; if (rdy !== 8'h00) begin n_bad++; $display("FAIL rst_mid_ready got %h want 00", rdy); end
    tick();
    n_cmp++; if (vout !== 1'b0 || dout !== 8'h00 || cout !== 3'd0) begin
      n_bad++; $display("FAIL rst_mid_out got %b/%h/%0d want 0/00/0", vout, dout, cout); end
    rst = 1'b0; vin = 8'h00;
    tick();
  endtask

`ifdef MUX_N_1_ROUND_ROBIN_EN
  task automatic test_round_robin();
    int exp_seq[4] = '{0, 3, 7, 0};
    mode = 1'b1; vin = 8'hFF; rdy_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_cmp++; if (rdy !== 8'(1 << (i % 8))) begin n_bad++; $display("FAIL rr_ready got %h want %h", rdy, 8'(1 << (i % 8))); end
      tick();
      n_cmp++; if (cout !== SW'(i % 8)) begin n_bad++; $display("FAIL rr_chan got %0d want %0d", cout, i % 8); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; vin = 8'h89;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (cout !== SW'(exp_seq[i]) || vout !== 1'b1) begin
        n_bad++; $display("FAIL rr_sparse got %b/%0d want 1/%0d", vout, cout, exp_seq[i]); end
    end
    mode = 1'b0; vin = 8'h00;
    tick();
  endtask
`else
  task automatic test_mode_ignored();
    mode = 1'b1; sel = 3'd4; vin = 8'hFF; rdy_in = 1'b1;
    #1;
    n_cmp++; if (rdy !== 8'h10) begin n_bad++; $display("FAIL mode_ign_ready got %h want 10", rdy); end
    tick();
    n_cmp++; if (cout !== 3'd4 || dout !== 8'hA4) begin n_bad++; $display("FAIL mode_ign_out got %h/%0d want a4/4", dout, cout); end
    mode = 1'b0; vin = 8'h00;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = '0; sel6 = '0;
    vin = '0; vin6 = '0; rdy_in = 1'b1; rdy_in6 = 1'b1;
    for (int c = 0; c < CH; c++)  din[c*DW +: DW]  = 8'(8'hA0 + c);
    for (int c = 0; c < CH6; c++) din6[c*DW +: DW] = 8'(8'hB0 + c);
    test_reset();
    test_fixed();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_out_of_range();
    test_reset_mid();
`ifdef MUX_N_1_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_mode_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
